// File: rtl/accum_datapath_rf_if.sv
// Command channel into the register-file datapath: one op per valid/ready handshake.
// The block drives cmd_ready; the command source holds the payload until it is accepted.
interface accum_datapath_rf_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_src;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/accum_datapath_rf.sv
// Register-file ALU datapath: single-cycle ops write at accept, MUL writes WIDTH cycles later.
// done pulses the cycle after a write; cmd_ready is low while a multiply is iterating.
module accum_datapath_rf #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  accum_datapath_rf_if.slave       cmd,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic                     zero
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic               ready_q;
  logic [WIDTH-1:0]   regs [NREGS];

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      mul_dst;

  logic               accept;
  logic [WIDTH-1:0]   opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               mul_last;

  // ready_q is cleared by reset, so no command is taken until the first edge after release
  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid & ready_q;
  assign rd_data       = regs[rd_addr];

  assign opnd_a = regs[cmd.cmd_dst];
  assign opnd_b = cmd.cmd_use_imm ? cmd.cmd_imm : regs[cmd.cmd_src];
  assign sum_w  = {1'b0, opnd_a} + {1'b0, opnd_b};
  assign diff_w = {1'b0, opnd_a} - {1'b0, opnd_b};

  always_comb begin
    alu_val = '0;
    alu_c   = 1'b0;
    case (cmd.cmd_op)
      OP_LOAD: alu_val = opnd_b;
      OP_ADD:  begin alu_val = sum_w[WIDTH-1:0];  alu_c = sum_w[WIDTH];  end
      OP_SUB:  begin alu_val = diff_w[WIDTH-1:0]; alu_c = diff_w[WIDTH]; end
      OP_AND:  alu_val = opnd_a & opnd_b;
      OP_OR:   alu_val = opnd_a | opnd_b;
      OP_XOR:  alu_val = opnd_a ^ opnd_b;
      OP_MUL:  alu_val = '0;
      OP_SHR:  begin alu_val = opnd_a >> 1; alu_c = opnd_a[0]; end
    endcase
  end

  // One shift-add step per cycle; the last step's sum is written straight to the file
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      mul_dst   <= '0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (cmd.cmd_op == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, opnd_a};
              mplier  <= opnd_b;
              prod    <= '0;
              cnt     <= '0;
              mul_dst <= cmd.cmd_dst;
              ready_q <= 1'b0;
              state   <= S_MUL;
            end else begin
              regs[cmd.cmd_dst] <= alu_val;
              result            <= alu_val;
              carry_out         <= alu_c;
              zero              <= (alu_val == '0);
              done              <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            regs[mul_dst] <= prod_nxt[WIDTH-1:0];
            result        <= prod_nxt[WIDTH-1:0];
            carry_out     <= |prod_nxt[2*WIDTH-1:WIDTH];
            zero          <= (prod_nxt[WIDTH-1:0] == '0);
            done          <= 1'b1;
            ready_q       <= 1'b1;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accum_datapath_rf.sv
// Bench for accum_datapath_rf: vector table, hand-written timing sequences and random ops
// against an arithmetic reference model; a second instance covers WIDTH=8, NREGS=8.
module tb_accum_datapath_rf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst8_n;

  accum_datapath_rf_if #(.WIDTH(4), .AW(2)) c4 ();
  logic [1:0] rd_addr4;
  logic [3:0] rd_data4, result4;
  logic       done4, carry4, zero4;

  accum_datapath_rf #(.WIDTH(4), .NREGS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(c4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .done(done4),
    .result(result4), .carry_out(carry4), .zero(zero4)
  );

  accum_datapath_rf_if #(.WIDTH(8), .AW(3)) c8 ();
  logic [2:0] rd_addr8;
  logic [7:0] rd_data8, result8;
  logic       done8, carry8, zero8;

  accum_datapath_rf #(.WIDTH(8), .NREGS(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .cmd(c8),
    .rd_addr(rd_addr8), .rd_data(rd_data8), .done(done8),
    .result(result8), .carry_out(carry8), .zero(zero8)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mregs [4];

  typedef struct {
    int op; int dst; int src; int ui; int imm; int xv; int xc;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Reference semantics for WIDTH=4 in plain integer arithmetic
  function automatic void model_op(input int op, input int a, input int b,
                                   output int v, output int c);
    v = 0; c = 0;
    case (op)
      0: v = b;
      1: begin v = (a + b) % 16; c = (a + b >= 16); end
      2: begin v = (a - b + 16) % 16; c = (a < b); end
      3: v = a & b;
      4: v = a | b;
      5: v = a ^ b;
      6: begin v = (a * b) % 16; c = (a * b >= 16); end
      default: begin v = a / 2; c = a % 2; end
    endcase
  endfunction

  // Issue one command on the 4-bit instance and check its completion; xv < 0 means use the model
  task automatic exec(input string nm, input int op, input int dst, input int src,
                      input int ui, input int imm, input int xv, input int xc);
    int a, b, mv, mc, n, lat, ev, ec;
    @(negedge clk);
    c4.cmd_valid = 1'b1;  c4.cmd_op = op[2:0];
    c4.cmd_dst = dst[1:0]; c4.cmd_src = src[1:0];
    c4.cmd_use_imm = ui[0]; c4.cmd_imm = imm[3:0];
    rd_addr4 = dst[1:0];
    n = 0;
    while (!c4.cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!c4.cmd_ready) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      c4.cmd_valid = 1'b0;
      return;
    end
    a = mregs[dst];
    b = ui ? imm : mregs[src];
    model_op(op, a, b, mv, mc);
    mregs[dst] = mv;
    ev = (xv < 0) ? mv : xv;
    ec = (xv < 0) ? mc : xc;
    @(posedge clk);
    @(negedge clk);
    c4.cmd_valid = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, lat, (op == 6) ? 5 : 1);
    chk({nm, "_result"},  int'(result4),  ev);
    chk({nm, "_carry"},   int'(carry4),   ec);
    chk({nm, "_zero"},    int'(zero4),    int'(ev == 0));
    chk({nm, "_rd_data"}, int'(rd_data4), ev);
  endtask

  task automatic reset4();
    @(negedge clk);
    rst_n = 1'b0;
    c4.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    @(negedge clk);
  endtask

  initial begin
    int low, early, lat;
    bit got_done;

    rst_n = 1'b0; rst8_n = 1'b0;
    c4.cmd_valid = 1'b0; c4.cmd_op = '0; c4.cmd_dst = '0; c4.cmd_src = '0;
    c4.cmd_use_imm = 1'b0; c4.cmd_imm = '0; rd_addr4 = '0;
    c8.cmd_valid = 1'b0; c8.cmd_op = '0; c8.cmd_dst = '0; c8.cmd_src = '0;
    c8.cmd_use_imm = 1'b0; c8.cmd_imm = '0; rd_addr8 = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 0;

    tbl[0]  = '{0, 1, 0, 1, 9,  9,  0};
    tbl[1]  = '{1, 1, 0, 1, 8,  1,  1};
    tbl[2]  = '{2, 0, 0, 1, 1,  15, 1};
    tbl[3]  = '{2, 0, 0, 1, 15, 0,  0};
    tbl[4]  = '{0, 2, 0, 1, 7,  7,  0};
    tbl[5]  = '{6, 2, 0, 1, 3,  5,  1};
    tbl[6]  = '{3, 2, 0, 1, 12, 4,  0};
    tbl[7]  = '{4, 2, 0, 1, 9,  13, 0};
    tbl[8]  = '{5, 2, 2, 0, 0,  0,  0};
    tbl[9]  = '{0, 3, 0, 1, 3,  3,  0};
    tbl[10] = '{7, 3, 0, 1, 6,  1,  1};
    tbl[11] = '{6, 1, 1, 0, 0,  1,  0};
    tbl[12] = '{1, 3, 1, 0, 0,  2,  0};
    tbl[13] = '{6, 0, 0, 1, 5,  0,  0};
    tbl[14] = '{2, 2, 1, 0, 0,  15, 1};

    // Reset state while held, then first cycle after release
    repeat (3) @(negedge clk);
    chk("rst_result", int'(result4), 0);
    chk("rst_carry",  int'(carry4), 0);
    chk("rst_zero",   int'(zero4), 0);
    chk("rst_done",   int'(done4), 0);
    chk("rst_ready",  int'(c4.cmd_ready), 0);
    rst_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", int'(c4.cmd_ready), 1);
    for (int i = 0; i < 4; i++) begin
      rd_addr4 = i[1:0];
      #1 chk("rel_rd_data", int'(rd_data4), 0);
    end

    // MUL busy window with a competing ADD held valid
    exec("ld_r2", 0, 2, 0, 1, 7, 7, 0);
    @(negedge clk);
    c4.cmd_valid = 1'b1; c4.cmd_op = 3'd6; c4.cmd_dst = 2'd2;
    c4.cmd_use_imm = 1'b1; c4.cmd_imm = 4'd3; rd_addr4 = 2'd1;
    chk("mul_ready", int'(c4.cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    c4.cmd_op = 3'd1; c4.cmd_dst = 2'd1; c4.cmd_imm = 4'd1;
    low = 0; early = 0;
    while (!c4.cmd_ready && low < 20) begin
      if (done4) early = 1;
      low++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", low, 4);
    chk("mul_early_done", early, 0);
    chk("mul_done", int'(done4), 1);
    chk("mul_result", int'(result4), 5);
    chk("mul_carry", int'(carry4), 1);
    chk("held_add_not_taken", int'(rd_data4), 0);
    @(posedge clk);
    @(negedge clk);
    c4.cmd_valid = 1'b0;
    chk("held_add_done", int'(done4), 1);
    chk("held_add_result", int'(result4), 1);
    mregs[2] = 5; mregs[1] = 1;

    // Back-to-back register-register ops, src == dst
    exec("ld_r3", 0, 3, 0, 1, 3, 3, 0);
    @(negedge clk);
    c4.cmd_valid = 1'b1; c4.cmd_op = 3'd1; c4.cmd_dst = 2'd3; c4.cmd_src = 2'd3;
    c4.cmd_use_imm = 1'b0;
    chk("b2b_ready", int'(c4.cmd_ready), 1);
    @(posedge clk); @(negedge clk);
    chk("b2b_done1", int'(done4), 1);
    chk("b2b_res1", int'(result4), 6);
    @(posedge clk); @(negedge clk);
    chk("b2b_done2", int'(done4), 1);
    chk("b2b_res2", int'(result4), 12);
    c4.cmd_op = 3'd7;
    @(posedge clk); @(negedge clk);
    c4.cmd_valid = 1'b0;
    chk("b2b_done3", int'(done4), 1);
    chk("b2b_res3", int'(result4), 6);
    chk("b2b_shr_carry", int'(carry4), 0);
    mregs[3] = 6;

    // Reset in the middle of a multiply
    reset4();
    exec("ld_r1", 0, 1, 0, 1, 5, 5, 0);
    @(negedge clk);
    c4.cmd_valid = 1'b1; c4.cmd_op = 3'd6; c4.cmd_dst = 2'd1;
    c4.cmd_use_imm = 1'b1; c4.cmd_imm = 4'd2; rd_addr4 = 2'd1;
    @(posedge clk); @(negedge clk);
    c4.cmd_valid = 1'b0;
    got_done = done4;
    @(negedge clk);
    rst_n = 1'b0;
    got_done |= done4;
    @(negedge clk);
    chk("abort_ready_in_rst", int'(c4.cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_done |= done4;
    chk("abort_no_done", int'(got_done), 0);
    chk("abort_r1", int'(rd_data4), 0);
    chk("abort_result", int'(result4), 0);
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    exec("abort_ld4", 0, 1, 0, 1, 4, 4, 0);

    // Vector table from a clean register file
    reset4();
    foreach (tbl[i]) exec("tbl", tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].ui,
                          tbl[i].imm, tbl[i].xv, tbl[i].xc);

    // Random ops against the model
    for (int i = 0; i < 60; i++)
      exec("rnd", int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
           int'($urandom_range(15, 0)), -1, 0);

    // WIDTH=8: abort a MUL, then 200 x 2
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      c8.cmd_valid = 1'b1; c8.cmd_op = 3'd0; c8.cmd_dst = 3'd5;
      c8.cmd_use_imm = 1'b1; c8.cmd_imm = 8'd200; rd_addr8 = 3'd5;
      @(posedge clk); @(negedge clk);
      chk("w8_load_res", int'(result8), 200);
      c8.cmd_op = 3'd6; c8.cmd_imm = 8'd2;
      chk("w8_mul_ready", int'(c8.cmd_ready), 1);
      @(posedge clk); @(negedge clk);
      c8.cmd_valid = 1'b0;
      if (pass == 0) begin
        got_done = done8;
        @(negedge clk);
        rst8_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        got_done |= done8;
        chk("w8_abort_no_done", int'(got_done), 0);
        chk("w8_abort_r5", int'(rd_data8), 0);
        chk("w8_abort_result", int'(result8), 0);
      end else begin
        lat = 1;
        while (!done8 && lat < 30) begin @(negedge clk); lat++; end
        chk("w8_mul_latency", lat, 9);
        chk("w8_mul_result", int'(result8), 144);
        chk("w8_mul_carry", int'(carry8), 1);
        chk("w8_mul_zero", int'(zero8), 0);
        chk("w8_mul_rd", int'(rd_data8), 144);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/accum_datapath_rf.md
# accum_datapath_rf

Parametrised successor to the 4-bit mux/register/ALU datapath. It replaces the single accumulator register with an NREGS-entry register file and widens the datapath to WIDTH bits. Commands arrive on a valid/ready handshake, and completion is reported as a registered result with carry and zero flags. It adds a multi-cycle shift-add multiply, so the block has a real busy state. It sits between the control FSM (command source) and the output/display logic (read port, result).

## Interface
- WIDTH, 4: datapath and register width (≥2)
- NREGS, 4: register-file depth, power of two ≥2; AW = $clog2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  operation code
- cmd_dst  in  AW  destination register, also operand A
- cmd_src  in  AW  source register for operand B
- cmd_use_imm  in  1  1: B = cmd_imm; 0: B = reg[cmd_src]
- cmd_imm  in  WIDTH  immediate operand
- rd_addr  in  AW  debug/read address
- rd_data  out  WIDTH  combinational reg[rd_addr]
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  last value written, registered
- carry_out  out  1  carry/borrow/shift-out flag, registered
- zero  out  1  result == 0, registered

## Operation
- Accept happens on a rising edge where cmd_valid & cmd_ready. A = reg[cmd_dst]. B is sampled at accept.
- Ops (all written to reg[cmd_dst]):
  - 000 LOAD: B; carry 0.
  - 001 ADD: A+B mod 2^WIDTH; carry = bit WIDTH of the sum.
  - 010 SUB: A−B mod 2^WIDTH; carry = borrow (1 iff A<B).
  - 011 AND, 100 OR, 101 XOR: bitwise; carry 0.
  - 110 MUL: low WIDTH bits of A×B; carry = 1 iff the high WIDTH bits are nonzero.
  - 111 SHR: A>>1, logical; carry = A[0]; B is ignored.
- At each write edge: result ← written value; zero ← (value==0); carry_out updated.
- Flags and result hold between writes.
- State machine:
  - IDLE: cmd_ready=1. A non-MUL accept writes on the same edge and stays in IDLE. A MUL accept captures A, B, clears the 2·WIDTH-bit product and goes to MUL.
  - MUL: cmd_ready=0. Iteration counter runs 0..WIDTH−1. Each edge adds the shifted multiplicand when the current multiplier bit is 1.
  - After the WIDTH-th iteration edge, the product is written and the block returns to IDLE.
- src==dst is legal; operands are always the pre-write values.
- Commands presented while busy are ignored. The source must hold them until ready.
- Reset (rst_n low, any time, including mid-MUL):
  - All registers, result, carry_out, zero, done cleared to 0; state IDLE.
  - cmd_ready is 0 while rst_n is low.
  - An aborted MUL writes nothing.

## Timing
- Single-cycle ops: write at the accept edge. done=1 for the following cycle only. rd_data shows the new value in that cycle.
- MUL: write at the edge WIDTH cycles after accept. done pulses in the cycle after that edge. cmd_ready is low for WIDTH cycles after accept.
- cmd_ready returns to 1 in the done cycle, so back-to-back accepts give one done per cycle for single-cycle ops.
- rd_data is combinational, zero-latency from rd_addr and register contents.
- Deassertion of rst_n takes effect at the next rising edge. No accept happens on that first edge if rst_n is still low at it.

## Test plan
Defaults WIDTH=4, NREGS=4 unless stated.
1. Reset → result=0, carry_out=0, zero=0, done=0, cmd_ready=0 while reset is held. After release, cmd_ready=1 and rd_data=0 for addresses 0..3.
2. LOAD r1,#9; then ADD r1,#8 → second done cycle: result=1, carry_out=1, zero=0; rd_data(r1)=1.
3. SUB r0,#1 (r0=0) → result=15, carry_out=1. Then SUB r0,#15 → result=0, zero=1, carry_out=0.
4. LOAD r2,#7; MUL r2,#3 → cmd_ready low exactly 4 cycles, and an ADD held valid meanwhile is not accepted. done follows with result=5 (21 mod 16) and carry_out=1. The held ADD is accepted in the done cycle.
5. Consecutive cycles, use_imm=0, src=dst=r3 (r3=3): ADD, ADD, SHR → done each cycle; results 6, 12, 6; SHR carry_out=0.
6. LOAD r1,#5, then MUL r1,#2 with rst_n pulled low 2 cycles after accept → no done. After release r1=0 and result=0; a new LOAD #4 completes normally. Repeat with WIDTH=8, NREGS=8: 200×2 → result=144, carry_out=1.
